// File: rtl/peripheral_bus_arbiter_pkg.sv
// Shared widths and the bus phase encoding for the Uniboard peripheral bus arbiter.
package uniboard_bus_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 8;
  localparam int PERIPH_W   = 7;
  localparam int SIZE_W     = 3;
  localparam int NUM_SELECT = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SEL1    = 3'd2,
    SEL2    = 3'd3,
    RELEASE = 3'd4
  } bus_state_t;

  // Index width for a requester pointer; a single bit is kept even for two masters.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/peripheral_bus_arbiter_if.sv
// Master request/response lines and the unidirectional peripheral bus lines.
interface peripheral_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import uniboard_bus_pkg::*;

  logic [NUM_MASTERS-1:0]          m_req;
  logic [NUM_MASTERS-1:0]          m_rw;
  logic [PERIPH_W*NUM_MASTERS-1:0] m_periph;
  logic [ADDR_W*NUM_MASTERS-1:0]   m_addr;
  logic [DATA_W*NUM_MASTERS-1:0]   m_wdata;
  logic [NUM_MASTERS-1:0]          m_grant;
  logic [NUM_MASTERS-1:0]          m_done;
  logic [DATA_W-1:0]               m_rdata;
  logic [SIZE_W-1:0]               m_rsize;

  logic [SIZE_W-1:0]               reg_size;
  logic [ADDR_W-1:0]               reg_addr;
  logic                            rw;
  logic [NUM_SELECT-1:0]           select;

  modport arb (
    input  m_req, m_rw, m_periph, m_addr, m_wdata, reg_size,
    output m_grant, m_done, m_rdata, m_rsize, reg_addr, rw, select
  );

  modport mst (
    output m_req, m_rw, m_periph, m_addr, m_wdata,
    input  m_grant, m_done, m_rdata, m_rsize
  );

  modport periph (
    input  reg_addr, rw, select,
    output reg_size
  );

endinterface

// File: rtl/peripheral_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after the last one served.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int MW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [MW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [MW-1:0] o_idx,
  output logic          o_valid
);

  logic [MW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = MW'((int'(i_last) + k) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Uniboard peripheral bus arbiter: round-robin master pick, fixed
// setup / select x2 / release phase sequence, tri-state write data.
module peripheral_bus_arbiter
  import uniboard_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = idx_w(NUM_MASTERS)
) (
  input  logic                  clk_12MHz,
  input  logic                  reset_n,
  peripheral_bus_arbiter_if.arb bus,
  inout  wire  [DATA_W-1:0]     databus
);

  bus_state_t r_state;
  bus_state_t w_state_next;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [MW-1:0]          r_last;
  logic                   r_rw;
  logic [PERIPH_W-1:0]    r_periph;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rdata;
  logic [SIZE_W-1:0]      r_rsize;

  logic [NUM_MASTERS-1:0] w_arb_grant;
  logic [MW-1:0]          w_arb_idx;
  logic                   w_arb_valid;
  logic                   w_sel_active;
  logic                   w_drive_en;
  logic [NUM_MASTERS-1:0] w_done;

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .MW (MW)
  ) u_rr_arbiter (
    .i_req   (bus.m_req),
    .i_last  (r_last),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_active = 1'b0;
    w_drive_en   = 1'b0;
    w_done       = '0;
    unique case (r_state)
      IDLE:    if (w_arb_valid) w_state_next = SETUP;
      SETUP: begin
        w_state_next = SEL1;
        w_drive_en   = !r_rw;
      end
      SEL1: begin
        w_state_next = SEL2;
        w_sel_active = 1'b1;
        w_drive_en   = !r_rw;
      end
      SEL2: begin
        w_state_next = RELEASE;
        w_sel_active = 1'b1;
        w_drive_en   = !r_rw;
      end
      RELEASE: begin
        w_state_next = IDLE;
        w_done       = r_grant;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Master inputs are only looked at on the IDLE->SETUP edge; the bus then runs from these copies.
  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_grant  <= '0;
      r_last   <= MW'(NUM_MASTERS - 1);
      r_rw     <= 1'b1;
      r_periph <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rsize  <= '0;
    end else begin
      if (r_state == IDLE && w_arb_valid) begin
        r_grant  <= w_arb_grant;
        r_last   <= w_arb_idx;
        r_rw     <= bus.m_rw[w_arb_idx];
        r_periph <= bus.m_periph[w_arb_idx*PERIPH_W +: PERIPH_W];
        r_addr   <= bus.m_addr[w_arb_idx*ADDR_W +: ADDR_W];
        r_wdata  <= bus.m_wdata[w_arb_idx*DATA_W +: DATA_W];
      end
      if (r_state == SEL2 && r_rw) begin
        r_rdata <= databus;
        r_rsize <= bus.reg_size;
      end
      if (r_state == RELEASE) begin
        r_grant <= '0;
      end
    end
  end

  localparam logic [NUM_SELECT-1:0] SEL_ONE = NUM_SELECT'(1);

  assign bus.select   = w_sel_active ? (SEL_ONE << r_periph) : '0;
  assign bus.reg_addr = r_addr;
  assign bus.rw       = r_rw;
  assign bus.m_grant  = r_grant;
  assign bus.m_done   = w_done;
  assign bus.m_rdata  = r_rdata;
  assign bus.m_rsize  = r_rsize;

  assign databus = w_drive_en ? r_wdata : 'z;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Scoreboard bench for peripheral_bus_arbiter with two masters and one peripheral model.
module tb_peripheral_bus_arbiter;

  localparam int NM = 2;

  logic clk_12MHz = 1'b0;
  logic reset_n   = 1'b0;
  wire  [31:0] databus;

  logic [31:0] per_data = '0;
  logic [2:0]  per_size = '0;

  peripheral_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  peripheral_bus_arbiter #(.NUM_MASTERS(NM)) dut (
    .clk_12MHz (clk_12MHz),
    .reset_n   (reset_n),
    .bus       (bus),
    .databus   (databus)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Peripheral model: answers reads while selected.
  assign databus      = (bus.rw && (bus.select != '0)) ? per_data : 'z;
  assign bus.reg_size = per_size;

  typedef struct {
    int          m;
    logic        rw;
    logic [6:0]  periph;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  rsize;
    bit          chk_period;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rdata = '0;
  logic [2:0]  model_rsize = '0;
  int          reqs_left[NM];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic set_master(input int m, input logic rw, input logic [6:0] p,
                            input logic [7:0] a, input logic [31:0] wd);
    bus.m_rw[m]              = rw;
    bus.m_periph[m*7 +: 7]   = p;
    bus.m_addr[m*8 +: 8]     = a;
    bus.m_wdata[m*32 +: 32]  = wd;
  endtask

  task automatic expect_txn(input int m, input logic rw, input logic [6:0] p,
                            input logic [7:0] a, input logic [31:0] wd, input bit per);
    exp_t e;
    if (rw) begin
      model_rdata = per_data;
      model_rsize = per_size;
    end
    e.m = m; e.rw = rw; e.periph = p; e.addr = a; e.wdata = wd;
    e.rdata = model_rdata; e.rsize = model_rsize; e.chk_period = per;
    sb_q.push_back(e);
  endtask

  task automatic run_until(input int ndone, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < ndone; c++) begin
      @(negedge clk_12MHz);
      for (int k = 0; k < NM; k++) begin
        if (bus.m_done[k]) begin
          seen++;
          reqs_left[k]--;
          if (reqs_left[k] <= 0) bus.m_req[k] = 1'b0;
        end
      end
    end
    if (seen < ndone) chk("done_timeout", seen, ndone);
  endtask

  task automatic wait_sel(input int nth);
    int hits = 0;
    for (int c = 0; c < 30 && hits < nth; c++) begin
      @(negedge clk_12MHz);
      if (bus.select != '0) hits++;
    end
    if (hits < nth) chk("select_timeout", hits, nth);
  endtask

  // Monitor: follows each granted transaction and scores it when m_done pulses.
  int          cyc = 0, sel_mask = 0, cycle_no = 0, last_done_cyc = 0;
  bit          active = 0, wd_ok = 1, nodrv_ok = 1;
  bit          multi_sel = 0, multi_grant = 0, idle_drv = 0;
  logic [127:0] obs_sel;
  logic [7:0]  obs_addr;
  logic        obs_rw;

  always @(negedge clk_12MHz) begin
    cycle_no++;
    if (!reset_n) begin
      active = 0;
    end else begin
      if ($countones(bus.select) > 1)  multi_sel = 1;
      if ($countones(bus.m_grant) > 1) multi_grant = 1;
      if (bus.m_grant != '0) begin
        if (!active) begin
          active = 1; cyc = 0; sel_mask = 0; wd_ok = 1; nodrv_ok = 1;
          obs_sel = '0; obs_addr = '0; obs_rw = 1'b0;
        end
        cyc++;
        if (bus.select != '0) begin
          sel_mask |= (1 << cyc);
          obs_sel  = bus.select;
          obs_addr = bus.reg_addr;
          obs_rw   = bus.rw;
        end
        if (sb_q.size() > 0) begin
          if (!sb_q[0].rw && cyc <= 3 && databus !== sb_q[0].wdata) wd_ok = 0;
          if ((sb_q[0].rw || cyc >= 4) && dut.w_drive_en) nodrv_ok = 0;
        end
      end else if (dut.w_drive_en) begin
        idle_drv = 1;
      end
      if (bus.m_done != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", bus.m_done, 0);
        end else begin
          exp_t e;
          logic [127:0] one;
          e   = sb_q.pop_front();
          one = 128'd1;
          chk("done_owner",  bus.m_done, one << e.m);
          chk("grant_owner", bus.m_grant, one << e.m);
          chk("txn_cycles",  cyc, 4);
          chk("sel_cycles",  sel_mask, 5'b01100);
          chk("sel_bit",     obs_sel, one << e.periph);
          chk("reg_addr",    obs_addr, e.addr);
          chk("addr_hold",   bus.reg_addr, e.addr);
          chk("rw",          obs_rw, e.rw);
          if (!e.rw) chk("wdata_on_bus", wd_ok, 1);
          chk("bus_drive",   nodrv_ok, 1);
          chk("rdata",       bus.m_rdata, e.rdata);
          chk("rsize",       bus.m_rsize, e.rsize);
          if (e.chk_period) chk("period", cycle_no - last_done_cyc, 5);
        end
        last_done_cyc = cycle_no;
        active = 0;
      end
    end
  end

  initial begin
    bus.m_req = '0; bus.m_rw = '0; bus.m_periph = '0; bus.m_addr = '0; bus.m_wdata = '0;
    for (int k = 0; k < NM; k++) reqs_left[k] = 0;

    repeat (3) @(negedge clk_12MHz);
    chk("rst_grant",  bus.m_grant, 0);
    chk("rst_done",   bus.m_done, 0);
    chk("rst_select", bus.select, 0);
    chk("rst_rw",     bus.rw, 1);
    chk("rst_addr",   bus.reg_addr, 0);
    chk("rst_rdata",  bus.m_rdata, 0);
    chk("rst_rsize",  bus.m_rsize, 0);
    chk("rst_drive",  dut.w_drive_en, 0);
    reset_n = 1'b1;
    @(negedge clk_12MHz);

    // single write from master 0
    set_master(0, 1'b0, 7'd2, 8'h05, 32'hDEADBEEF);
    expect_txn(0, 1'b0, 7'd2, 8'h05, 32'hDEADBEEF, 0);
    reqs_left[0] = 1; bus.m_req[0] = 1'b1;
    run_until(1, 40);
    repeat (2) @(negedge clk_12MHz);

    // single read from master 1
    per_data = 32'h12345678; per_size = 3'd2;
    set_master(1, 1'b1, 7'd2, 8'h09, 32'h0);
    expect_txn(1, 1'b1, 7'd2, 8'h09, 32'h0, 0);
    reqs_left[1] = 1; bus.m_req[1] = 1'b1;
    run_until(1, 40);
    repeat (2) @(negedge clk_12MHz);

    // both masters request back to back: 0,1,0,1,0,1 at one per 5 cycles
    per_data = 32'h0BADF00D; per_size = 3'd5;
    set_master(0, 1'b0, 7'd3, 8'h10, 32'hA5A50000);
    set_master(1, 1'b1, 7'd4, 8'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) expect_txn(0, 1'b0, 7'd3, 8'h10, 32'hA5A50000, i > 0);
      else            expect_txn(1, 1'b1, 7'd4, 8'h20, 32'h0, 1);
    end
    reqs_left[0] = 3; reqs_left[1] = 3;
    bus.m_req = 2'b11;
    run_until(6, 100);
    repeat (2) @(negedge clk_12MHz);

    // master 0 changes its inputs mid-transaction
    set_master(0, 1'b0, 7'd5, 8'h33, 32'hCAFEF00D);
    expect_txn(0, 1'b0, 7'd5, 8'h33, 32'hCAFEF00D, 0);
    reqs_left[0] = 1; bus.m_req[0] = 1'b1;
    wait_sel(1);
    bus.m_req[0] = 1'b0;
    set_master(0, 1'b0, 7'd6, 8'h77, 32'h0);
    run_until(1, 40);
    repeat (2) @(negedge clk_12MHz);

    // reset during SEL2 of a master-1 read
    per_data = 32'h55AA55AA; per_size = 3'd7;
    set_master(1, 1'b1, 7'd1, 8'h44, 32'h0);
    bus.m_req[1] = 1'b1;
    wait_sel(2);
    reset_n = 1'b0;
    #1;
    chk("abort_select", bus.select, 0);
    chk("abort_drive",  dut.w_drive_en, 0);
    chk("abort_done",   bus.m_done, 0);
    chk("abort_grant",  bus.m_grant, 0);
    chk("abort_rdata",  bus.m_rdata, 0);
    model_rdata = '0; model_rsize = '0;
    per_data = 32'h12345678; per_size = 3'd2;
    set_master(0, 1'b0, 7'd2, 8'h06, 32'h01020304);
    set_master(1, 1'b1, 7'd2, 8'h0A, 32'h0);
    expect_txn(0, 1'b0, 7'd2, 8'h06, 32'h01020304, 0);
    expect_txn(1, 1'b1, 7'd2, 8'h0A, 32'h0, 0);
    reqs_left[0] = 1; reqs_left[1] = 1;
    bus.m_req = 2'b11;
    repeat (2) @(negedge clk_12MHz);
    chk("abort_hold_done", bus.m_done, 0);
    reset_n = 1'b1;
    run_until(2, 60);
    repeat (2) @(negedge clk_12MHz);

    // write after read keeps the read result
    per_data = 32'hFACEFACE; per_size = 3'd6;
    set_master(0, 1'b0, 7'd7, 8'h7F, 32'hFFFF0000);
    expect_txn(0, 1'b0, 7'd7, 8'h7F, 32'hFFFF0000, 0);
    reqs_left[0] = 1; bus.m_req[0] = 1'b1;
    run_until(1, 40);
    repeat (3) @(negedge clk_12MHz);
    chk("rdata_after_write", bus.m_rdata, 32'h12345678);
    chk("rsize_after_write", bus.m_rsize, 3'd2);

    chk("select_onehot", multi_sel, 0);
    chk("grant_onehot",  multi_grant, 0);
    chk("idle_drive",    idle_drv, 0);
    chk("sb_empty",      sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/peripheral_bus_arbiter.md
# peripheral_bus_arbiter

Shares the single Uniboard peripheral bus (databus, reg_size, reg_addr, rw, select) among several bus masters, e.g. the UART protocol interface and autonomous pollers such as a safety watchdog. Runs every bus access through one fixed phase sequence: setup, select high for two cycles, release. Chooses the next master round-robin and returns read data and register size to the master it served.

## Interface
- NUM_MASTERS, 2, number of requesters (2..8)
- MW, $clog2(NUM_MASTERS) (min 1), pointer/index width
- clk_12MHz  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  reset; asynchronous assert, active-low
- m_req  in  NUM_MASTERS  per-master level request; held until that master's m_done
- m_rw  in  NUM_MASTERS  per-master 0 = write, 1 = read
- m_periph  in  7*NUM_MASTERS  per-master peripheral index (select bit)
- m_addr  in  8*NUM_MASTERS  per-master register address
- m_wdata  in  32*NUM_MASTERS  per-master write data
- m_grant  out  NUM_MASTERS  one-hot owner, high from SETUP through RELEASE
- m_done  out  NUM_MASTERS  one-cycle pulse to the owner at transaction end
- m_rdata  out  32  read data from the last completed read (shared)
- m_rsize  out  3  reg_size from the last completed read (shared)
- databus  inout  32  peripheral data bus; driven only during write phases
- reg_size  in  3  register size from the selected peripheral
- reg_addr  out  8  register address to peripherals
- rw  out  1  bus direction (1 = read)
- select  out  128  per-peripheral select, at most one bit high

## Operation
- States: IDLE, SETUP, SEL1, SEL2, RELEASE.
- IDLE:
  - If any m_req is high, pick a winner by round-robin, starting at last_served+1 mod NUM_MASTERS.
  - Latch the winner's rw, periph, addr and wdata into internal registers. Set m_grant and last_served. Go to SETUP.
- SETUP: reg_addr, rw and write data are driven; select = 0. Go to SEL1.
- SEL1: select[periph] = 1. Go to SEL2.
- SEL2: select[periph] = 1. On a read, capture databus → m_rdata and reg_size → m_rsize at the end of SEL2. Go to RELEASE.
- RELEASE:
  - select = 0; m_done[owner] = 1 for this one cycle; reg_addr and rw are held.
  - Go to IDLE. m_grant clears on entering IDLE.
- Masters' inputs are sampled only at the IDLE→SETUP edge. Later changes, including dropping m_req, do not affect the transaction in flight, and m_done still pulses.
- Write transactions leave m_rdata and m_rsize unchanged.
- databus is driven with the latched wdata only when rw = 0 and the state is SETUP, SEL1 or SEL2. Otherwise it is high-Z, including IDLE, RELEASE and all reads.
- A master whose m_req is still high after m_done counts as a new request and waits its round-robin turn.

## Timing
- Reset values (asynchronous on reset_n low):
  - state IDLE; select 0; m_grant 0; m_done 0; rw 1; reg_addr 0; databus high-Z
  - m_rdata 0; m_rsize 0; last_served NUM_MASTERS-1, so master 0 wins first.
- Reset mid-transaction: select drops and databus releases immediately. The aborted transaction gets no m_done.
- Latency, with request seen at edge E0 in IDLE:
  - SETUP after E0; select high after E1 and E2
  - read captured at E3; m_done high between E3 and E4
  - IDLE after E4; next arbitration at E5
- One transaction takes 5 cycles; sustained throughput is 1 per 5 cycles.
- select is never high in SETUP or RELEASE, so the bus is always configured one cycle before select rises and held one cycle after it falls.
- Simultaneous requests: exactly one m_grant bit; the others wait. With N masters all requesting, each is served within N transactions.

## Structure
- Package uniboard_bus_pkg holds:
  - DATA_W = 32, ADDR_W = 8, PERIPH_W = 7, SIZE_W = 3, NUM_SELECT = 128
  - the bus_state_t enum (IDLE, SETUP, SEL1, SEL2, RELEASE)
- Sub-module rr_arbiter:
  - combinational; inputs req vector and last_served pointer
  - outputs one-hot grant and encoded index
  - instantiated once.
- The top level holds the FSM, latch registers, select decoder and tri-state databus driver.

## Test plan
- Reset, then master 0 writes periph 2, addr 0x05, data 0xDEADBEEF:
  - databus = 0xDEADBEEF in SETUP–SEL2
  - select[2] high for exactly two cycles
  - m_done[0] pulses once, 4 cycles after the grant edge.
- Master 1 reads periph 2 while the model drives 0x12345678 and reg_size = 2 during select: m_rdata = 0x12345678, m_rsize = 2, and the arbiter never drives databus.
- Masters 0 and 1 request continuously for 6 transactions: grants alternate 0,1,0,1,0,1; no overlap in select; every transaction is 5 cycles.
- Master 0 drops m_req and changes m_addr during SEL1: the bus keeps the latched address and m_done[0] still pulses.
- reset_n low during SEL2 of a read: select = 0 and databus high-Z immediately; no m_done; after release, master 0 wins first.
- Write after read: m_rdata keeps the prior read value (0x12345678) after the write completes.
